imem: RTL and testbench

- Read-only instruction memory for the single-cycle LEGv8 processor.
- Holds a fixed 64-word program image of 32-bit instructions, indexed by word address.
- Gives a combinational read port for the single-cycle datapath and a registered copy of the same data for pipelined or debug use.
- Sits between the PC logic (which drives addr) and the instruction decoder (which consumes q).

---
 rtl/imem_pkg.sv | 41 ++++
 rtl/imem.sv | 36 +++
 tb/tb_imem.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared constants for the LEGv8 instruction memory: geometry, program image
// and opcode values reused by the decoder.
package imem_pkg;

  localparam int IMEM_ADDR_W = 6;
  localparam int IMEM_DATA_W = 32;
  localparam int IMEM_DEPTH  = 1 << IMEM_ADDR_W;

  typedef logic [31:0] instr_t;

  // Opcode fields as seen by the decoder (R/D-format use 11 bits, CB uses 8).
  localparam logic [10:0] OPC_STUR = 11'h7C0;
  localparam logic [10:0] OPC_LDUR = 11'h7C2;
  localparam logic [10:0] OPC_SUB  = 11'h658;
  localparam logic [10:0] OPC_ADD  = 11'h458;
  localparam logic [7:0]  OPC_CBZ  = 8'hB4;

  localparam instr_t IMEM_IMAGE [0:IMEM_DEPTH-1] = '{
    0:       32'hf8000000,
    1:       32'hf8008001,
    2:       32'hf8010002,
    3:       32'hf8018003,
    4:       32'hf8020004,
    5:       32'hf8028005,
    6:       32'hf8030006,
    7:       32'hf8400007,
    8:       32'hf8408008,
    9:       32'hf8410009,
    10:      32'hf841800a,
    11:      32'hf842000b,
    12:      32'hf842800c,
    13:      32'hf843000d,
    14:      32'hcb0e01ce,
    15:      32'hb400004e,
    16:      32'hcb01000f,
    17:      32'h8b01000f,
    18:      32'hf803800f,
    default: 32'h00000000
  };

endpackage

// File: rtl/imem.sv
// Read-only instruction memory: combinational word read for the single-cycle
// datapath plus a registered copy of the same word.
module imem
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] q_r
);

  logic [DATA_W-1:0] w_q;
  logic [DATA_W-1:0] r_q;

  // ROM lookup; every address is in range, unused entries hold zero.
  always_comb begin
    w_q = IMEM_IMAGE[addr];
  end

  // Registered copy; reset clears only this path, never the combinational one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= {DATA_W{1'b0}};
    end else begin
      r_q <= w_q;
    end
  end

  assign q   = w_q;
  assign q_r = r_q;

endmodule

// File: tb/tb_imem.sv
// Scoreboard bench for imem: stimulus pushes expected values, monitors pop and compare.
module tb_imem;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  addr = 6'd0;
  logic [31:0] q;
  logic [31:0] q_r;

  imem dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .q    (q),
    .q_r  (q_r)
  );

  always #5 clk = ~clk;

  logic [31:0] prog [0:18] = '{
    32'hf8000000, 32'hf8008001, 32'hf8010002, 32'hf8018003, 32'hf8020004,
    32'hf8028005, 32'hf8030006, 32'hf8400007, 32'hf8408008, 32'hf8410009,
    32'hf841800a, 32'hf842000b, 32'hf842800c, 32'hf843000d, 32'hcb0e01ce,
    32'hb400004e, 32'hcb01000f, 32'h8b01000f, 32'hf803800f
  };

  function automatic logic [31:0] ref_word(input int a);
    return (a < 19) ? prog[a] : 32'h0;
  endfunction

  typedef struct {
    bit          on_reg;
    logic [31:0] exp;
    string       tag;
  } chk_t;

  chk_t        comb_sb [$];
  logic [31:0] reg_sb  [$];
  logic [31:0] model_qr = 32'h0;
  int          n_vec = 0;
  int          n_err = 0;

  // Immediate checks of q (or held q_r) between edges.
  always begin
    chk_t it;
    wait (comb_sb.size() != 0);
    it = comb_sb.pop_front();
    n_vec++;
    if (it.on_reg) begin
      if (q_r !== it.exp) begin
        n_err++;
        $display("FAIL %s: q_r=%h expected %h (addr=%0d)", it.tag, q_r, it.exp, addr);
      end
    end else begin
      if (q !== it.exp) begin
        n_err++;
        $display("FAIL %s: q=%h expected %h (addr=%0d)", it.tag, q, it.exp, addr);
      end
    end
  end

  // Registered-path check just after each rising edge that has an expectation.
  always @(posedge clk) begin
    logic [31:0] e;
    #1;
    if (reg_sb.size() != 0) begin
      e = reg_sb.pop_front();
      n_vec++;
      if (q_r !== e) begin
        n_err++;
        $display("FAIL q_r_edge: q_r=%h expected %h (addr=%0d reset=%b)", q_r, e, addr, reset);
      end
    end
  end

  task automatic check_q(input string tag);
    chk_t it;
    #1;
    it.on_reg = 1'b0;
    it.exp    = ref_word(int'(addr));
    it.tag    = tag;
    comb_sb.push_back(it);
    #1;
  endtask

  task automatic check_hold(input string tag);
    chk_t it;
    it.on_reg = 1'b1;
    it.exp    = model_qr;
    it.tag    = tag;
    comb_sb.push_back(it);
    #1;
  endtask

  // One rising edge with the current addr/reset; expectation queued beforehand.
  task automatic cycle();
    model_qr = reset ? 32'h0 : ref_word(int'(addr));
    reg_sb.push_back(model_qr);
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset held for two edges with addr = 7.
    addr  = 6'd7;
    reset = 1'b1;
    check_q("reset_q");
    cycle();
    check_q("reset_q_1");
    cycle();
    check_q("reset_q_2");

    // Full combinational sweep, including zero-filled tail and addr 63.
    for (int a = 0; a < 64; a++) begin
      addr = 6'(a);
      #5;
      check_q("sweep");
    end

    // Release reset; 17 then 16 on successive edges.
    reset = 1'b0;
    addr  = 6'd17;
    cycle();
    addr  = 6'd16;
    cycle();

    // Mid-stream reset with addr = 1, then release.
    addr  = 6'd1;
    reset = 1'b1;
    cycle();
    check_q("mid_reset_q");
    reset = 1'b0;
    check_hold("post_release_hold");
    cycle();

    // Address changes between edges: q follows, q_r holds.
    addr = 6'd3;
    cycle();
    for (int a = 4; a <= 6; a++) begin
      addr = 6'(a);
      check_q("between_edges_q");
      check_hold("between_edges_qr");
    end
    cycle();

    // Randomized addresses with occasional reset.
    for (int i = 0; i < 300; i++) begin
      addr  = 6'($urandom_range(0, 63));
      reset = ($urandom_range(0, 9) == 0);
      check_q("rand_q");
      cycle();
    end
    reset = 1'b0;

    // Drain with a bounded wait.
    repeat (3) @(posedge clk);
    #3;
    n_vec++;
    if (comb_sb.size() != 0 || reg_sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: comb=%0d reg=%0d pending, expected 0", comb_sb.size(), reg_sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
